// File: rtl/gpr_mp_pkg.sv
// Shared widths and types for the multi-port architectural register file.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package gpr_mp_pkg;

  localparam int WORD_WIDTH     = 32;
  localparam int GPR_ADDR_WIDTH = 5;
  localparam int GPR_NREG       = 1 << GPR_ADDR_WIDTH;

  typedef logic [WORD_WIDTH-1:0]     word_t;
  typedef logic [GPR_ADDR_WIDTH-1:0] gpr_addr_t;

endpackage

// File: rtl/gpr_mp_if.sv
// Commit-write / operand-read bundle between ROB commit, dispatch and the GPR file.
// Latency: n/a (wires only).
// Backpressure: none; every commit and read is taken in the cycle it is presented.
// Ports: commit_en/addr/data (NUM_WR packed lanes), rd_en/rd_addr (NUM_RD lanes), rd_data back.
interface gpr_mp_if #(
  parameter int NUM_WR = 2,
  parameter int NUM_RD = 3,
  parameter int XLEN   = gpr_mp_pkg::WORD_WIDTH,
  parameter int AW     = gpr_mp_pkg::GPR_ADDR_WIDTH
);

  logic [NUM_WR-1:0]      commit_en;
  logic [NUM_WR*AW-1:0]   commit_addr;
  logic [NUM_WR*XLEN-1:0] commit_data;
  logic [NUM_RD-1:0]      rd_en;
  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;

  modport master (
    output commit_en, commit_addr, commit_data, rd_en, rd_addr,
    input  rd_data
  );

  modport slave (
    input  commit_en, commit_addr, commit_data, rd_en, rd_addr,
    output rd_data
  );

endinterface

// File: rtl/gpr_mp_wsel.sv
// Youngest-wins match of one address against all commit lanes -> hit + data.
// Latency: combinational.
// Backpressure: none.
// Ports: addr (address to match), en/waddr/wdata (packed commit lanes), hit, data (0 when no hit).
module gpr_mp_wsel import gpr_mp_pkg::*; #(
  parameter int NUM_WR = 2,
  parameter int XLEN   = WORD_WIDTH,
  parameter int AW     = GPR_ADDR_WIDTH
) (
  input  logic [AW-1:0]          addr,
  input  logic [NUM_WR-1:0]      en,
  input  logic [NUM_WR*AW-1:0]   waddr,
  input  logic [NUM_WR*XLEN-1:0] wdata,
  output logic                   hit,
  output logic [XLEN-1:0]        data
);

  // Scanning upward lets the highest (youngest) matching lane overwrite older ones.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      if (en[w] && (waddr[w*AW +: AW] == addr)) begin
        hit  = 1'b1;
        data = wdata[w*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/gpr_mp.sv
// Architectural register file: NUM_WR commit write lanes, NUM_RD operand read lanes, x0 optionally hardwired 0.
// Latency: RD_LAT=0 combinational read; RD_LAT=1 address sampled at edge, data next cycle. Writes land at the edge.
// Backpressure: none; all commits accepted in their cycle, reads never stall.
// Ports: clk, rst_n (async active-low), bus (gpr_mp_if slave: commit lanes in, read lanes in, rd_data out).
module gpr_mp import gpr_mp_pkg::*; #(
  parameter int         XLEN        = WORD_WIDTH,
  parameter int         NREG        = GPR_NREG,
  parameter int         AW          = GPR_ADDR_WIDTH,
  parameter int         NUM_WR      = 2,
  parameter int         NUM_RD      = 3,
  parameter logic [7:0] BYPASS_MASK = 8'b0000_0011,
  parameter bit         RD_LAT      = 1'b0,
  parameter bit         X0_ZERO     = 1'b1
) (
  input logic     clk,
  input logic     rst_n,
  gpr_mp_if.slave bus
);

  logic [NUM_WR-1:0] wen;
  logic [XLEN-1:0]   arr    [NREG];
  logic [XLEN-1:0]   rd_val [NUM_RD];

  // Commits to x0 are dropped here so neither the array nor the bypass ever sees them.
  always_comb begin
    wen = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      wen[w] = bus.commit_en[w] && !(X0_ZERO && (bus.commit_addr[w*AW +: AW] == '0));
    end
  end

  // Storage: one flop word per entry, each with its own youngest-wins selector.
  for (genvar i = 0; i < NREG; i++) begin : g_ent
    localparam logic [AW-1:0] IDX = AW'(i);
    logic            hit;
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] q;

    gpr_mp_wsel #(.NUM_WR(NUM_WR), .XLEN(XLEN), .AW(AW)) u_wsel (
      .addr  (IDX),
      .en    (wen),
      .waddr (bus.commit_addr),
      .wdata (bus.commit_data),
      .hit   (hit),
      .data  (data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= '0;
      end else if (hit) begin
        q <= data;
      end
    end

    assign arr[i] = q;
  end

  // Read lanes: optional same-cycle bypass, then optional output register.
  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] cur;

    assign addr = bus.rd_addr[r*AW +: AW];

    if (BYPASS_MASK[r]) begin : g_byp
      logic            byp_hit;
      logic [XLEN-1:0] byp_data;

      gpr_mp_wsel #(.NUM_WR(NUM_WR), .XLEN(XLEN), .AW(AW)) u_wsel (
        .addr  (addr),
        .en    (wen),
        .waddr (bus.commit_addr),
        .wdata (bus.commit_data),
        .hit   (byp_hit),
        .data  (byp_data)
      );

      // Bypass is suppressed under reset: commits presented then are lost and must not leak out.
      always_comb begin
        cur = arr[addr];
        if (byp_hit && rst_n) begin
          cur = byp_data;
        end
        if (X0_ZERO && (addr == '0)) begin
          cur = '0;
        end
      end
    end else begin : g_nobyp
      always_comb begin
        cur = arr[addr];
        if (X0_ZERO && (addr == '0)) begin
          cur = '0;
        end
      end
    end

    if (RD_LAT) begin : g_reg
      logic [XLEN-1:0] q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q <= '0;
        end else if (bus.rd_en[r]) begin
          q <= cur;
        end
      end

      assign rd_val[r] = q;
    end else begin : g_comb
      assign rd_val[r] = cur;
    end
  end

  always_comb begin
    bus.rd_data = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      bus.rd_data[r*XLEN +: XLEN] = rd_val[r];
    end
  end

endmodule

// File: tb/tb_gpr_mp.sv
// Bench for gpr_mp: three configurations (2x3 comb read, 2x3 registered read, 4x8 registered read)
// driven from one stimulus set and compared against an array-based reference model.
// Ports: none (top-level bench).
module tb_gpr_mp;
  import gpr_mp_pkg::*;

  localparam logic [7:0] MASK_AB = 8'b0000_0011;
  localparam logic [7:0] MASK_C  = 8'b1010_0111;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gpr_mp_if #(.NUM_WR(2), .NUM_RD(3)) if_a ();
  gpr_mp_if #(.NUM_WR(2), .NUM_RD(3)) if_b ();
  gpr_mp_if #(.NUM_WR(4), .NUM_RD(8)) if_c ();

  gpr_mp #(.NUM_WR(2), .NUM_RD(3), .BYPASS_MASK(MASK_AB), .RD_LAT(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a));
  gpr_mp #(.NUM_WR(2), .NUM_RD(3), .BYPASS_MASK(MASK_AB), .RD_LAT(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b));
  gpr_mp #(.NUM_WR(4), .NUM_RD(8), .BYPASS_MASK(MASK_C), .RD_LAT(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .bus(if_c));

  // Stimulus, sized for the widest configuration; the 2x3 instances see the low lanes.
  logic [3:0]  c_en;
  logic [4:0]  c_addr [4];
  logic [31:0] c_data [4];
  logic [7:0]  r_en;
  logic [4:0]  r_addr [8];

  always_comb begin
    if_a.commit_en = c_en[1:0];  if_b.commit_en = c_en[1:0];  if_c.commit_en = c_en;
    if_a.rd_en     = r_en[2:0];  if_b.rd_en     = r_en[2:0];  if_c.rd_en     = r_en;
    if_a.commit_addr = '0; if_a.commit_data = '0; if_a.rd_addr = '0;
    if_b.commit_addr = '0; if_b.commit_data = '0; if_b.rd_addr = '0;
    if_c.commit_addr = '0; if_c.commit_data = '0; if_c.rd_addr = '0;
    for (int w = 0; w < 4; w++) begin
      if_c.commit_addr[w*5 +: 5]  = c_addr[w];
      if_c.commit_data[w*32 +: 32] = c_data[w];
    end
    for (int w = 0; w < 2; w++) begin
      if_a.commit_addr[w*5 +: 5]  = c_addr[w];
      if_a.commit_data[w*32 +: 32] = c_data[w];
      if_b.commit_addr[w*5 +: 5]  = c_addr[w];
      if_b.commit_data[w*32 +: 32] = c_data[w];
    end
    for (int r = 0; r < 8; r++) if_c.rd_addr[r*5 +: 5] = r_addr[r];
    for (int r = 0; r < 3; r++) begin
      if_a.rd_addr[r*5 +: 5] = r_addr[r];
      if_b.rd_addr[r*5 +: 5] = r_addr[r];
    end
  end

  // Reference model: plain register arrays plus expected registered outputs.
  logic [31:0] mem_ab [32];
  logic [31:0] mem_c  [32];
  logic [31:0] exp_b  [3];
  logic [31:0] exp_c  [8];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) begin mem_ab[i] = '0; mem_c[i] = '0; end
    for (int r = 0; r < 3; r++) exp_b[r] = '0;
    for (int r = 0; r < 8; r++) exp_c[r] = '0;
  endtask

  // What a read lane should return right now: 0 for x0 or under reset, else the
  // newest value among the array and (if this lane bypasses) this cycle's commits.
  function automatic logic [31:0] model_rd(input bit is_c, input int r);
    logic [31:0] v;
    int nwr;
    bit byp;
    nwr = is_c ? 4 : 2;
    byp = is_c ? MASK_C[r] : MASK_AB[r];
    if (!rst_n || r_addr[r] == 5'd0) return 32'd0;
    v = is_c ? mem_c[r_addr[r]] : mem_ab[r_addr[r]];
    if (byp)
      for (int w = 0; w < nwr; w++)
        if (c_en[w] && c_addr[w] == r_addr[r]) v = c_data[w];
    return v;
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      clear_model();
    end else begin
      for (int w = 0; w < 2; w++) if (c_en[w] && c_addr[w] != 5'd0) mem_ab[c_addr[w]] = c_data[w];
      for (int w = 0; w < 4; w++) if (c_en[w] && c_addr[w] != 5'd0) mem_c[c_addr[w]]  = c_data[w];
    end
  endtask

  // Called just after a negedge with inputs set; returns on the following negedge.
  task automatic step();
    logic [255:0] e;
    logic [31:0]  nb [3];
    logic [31:0]  nc [8];
    #1;
    e = '0;
    for (int r = 0; r < 3; r++) e[r*32 +: 32] = model_rd(1'b0, r);
    chk("lat0_2x3", 256'(if_a.rd_data), e);
    for (int r = 0; r < 3; r++) nb[r] = !rst_n ? 32'd0 : (r_en[r] ? model_rd(1'b0, r) : exp_b[r]);
    for (int r = 0; r < 8; r++) nc[r] = !rst_n ? 32'd0 : (r_en[r] ? model_rd(1'b1, r) : exp_c[r]);
    @(posedge clk);
    model_edge();
    for (int r = 0; r < 3; r++) exp_b[r] = nb[r];
    for (int r = 0; r < 8; r++) exp_c[r] = nc[r];
    #1;
    e = '0;
    for (int r = 0; r < 3; r++) e[r*32 +: 32] = exp_b[r];
    chk("lat1_2x3", 256'(if_b.rd_data), e);
    e = '0;
    for (int r = 0; r < 8; r++) e[r*32 +: 32] = exp_c[r];
    chk("lat1_4x8", 256'(if_c.rd_data), e);
    @(negedge clk);
  endtask

  task automatic idle();
    c_en = '0;
    r_en = '1;
    for (int w = 0; w < 4; w++) begin c_addr[w] = '0; c_data[w] = '0; end
  endtask

  task automatic set_rd_all(input logic [4:0] a);
    for (int r = 0; r < 8; r++) r_addr[r] = a;
  endtask

  logic [31:0] held;

  initial begin
    rst_n = 1'b0;
    idle();
    set_rd_all(5'd0);
    clear_model();
    @(negedge clk);
    step();
    rst_n = 1'b1;

    // Freshly reset file reads zero everywhere.
    for (int a = 0; a < 32; a++) begin
      set_rd_all(5'(a));
      step();
    end

    // Single commit: bypass lanes see it now, lane 2 only after the edge.
    c_en = 4'b0001; c_addr[0] = 5'd5; c_data[0] = 32'hDEADBEEF;
    set_rd_all(5'd5);
    #1;
    chk("t2_p0_byp", 256'(if_a.rd_data[31:0]), 256'(32'hDEADBEEF));
    chk("t2_p1_byp", 256'(if_a.rd_data[63:32]), 256'(32'hDEADBEEF));
    chk("t2_p2_nobyp", 256'(if_a.rd_data[95:64]), 256'(32'h0));
    step();
    chk("t2_lat1_p0", 256'(if_b.rd_data[31:0]), 256'(32'hDEADBEEF));
    chk("t2_lat1_p2", 256'(if_b.rd_data[95:64]), 256'(32'h0));
    idle();
    #1;
    chk("t2_p2_next", 256'(if_a.rd_data[95:64]), 256'(32'hDEADBEEF));
    step();

    // Same-address collision: the younger lane wins in bypass and array.
    c_en = 4'b0011;
    c_addr[0] = 5'd7; c_data[0] = 32'h1111;
    c_addr[1] = 5'd7; c_data[1] = 32'h2222;
    set_rd_all(5'd7);
    #1;
    chk("t3_byp_p0", 256'(if_a.rd_data[31:0]), 256'(32'h2222));
    step();
    idle();
    #1;
    chk("t3_arr_p2", 256'(if_a.rd_data[95:64]), 256'(32'h2222));
    step();

    // x0 ignores commits and always reads zero.
    c_en = 4'b0010; c_addr[1] = 5'd0; c_data[1] = 32'hFFFFFFFF;
    set_rd_all(5'd0);
    #1;
    chk("t4_x0_now", 256'(if_a.rd_data), 256'd0);
    step();
    idle();
    step();
    chk("t4_x0_lat1", 256'(if_b.rd_data), 256'd0);

    // Mid-cycle reset clears everything at once and swallows the pending commit.
    c_en = 4'b0001; c_addr[0] = 5'd9; c_data[0] = 32'hA5A5;
    set_rd_all(5'd9);
    step();
    c_en = 4'b0001; c_addr[0] = 5'd9; c_data[0] = 32'h5A5A;
    #1;
    chk("t5_pre_rst", 256'(if_a.rd_data[95:64]), 256'(32'hA5A5));
    rst_n = 1'b0;
    clear_model();
    #1;
    chk("t5_rst_a", 256'(if_a.rd_data), 256'd0);
    chk("t5_rst_b", 256'(if_b.rd_data), 256'd0);
    chk("t5_rst_c", 256'(if_c.rd_data), 256'd0);
    step();
    rst_n = 1'b1;
    idle();
    step();
    chk("t5_after_b", 256'(if_b.rd_data), 256'd0);

    // Registered lane with rd_en low holds while its address and the array change.
    r_addr[1] = 5'd3; c_en = 4'b0001; c_addr[0] = 5'd3; c_data[0] = 32'h33;
    step();
    held = exp_b[1];
    chk("t6_capture", 256'(if_b.rd_data[63:32]), 256'(32'h33));
    r_en[1] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      r_addr[1] = 5'($urandom % 32);
      c_en = 4'b0011;
      c_addr[0] = r_addr[1]; c_data[0] = $urandom;
      c_addr[1] = 5'd3;      c_data[1] = $urandom;
      step();
      chk("t6_hold", 256'(if_b.rd_data[63:32]), 256'(held));
    end
    idle();

    // Random traffic with address clustering for collisions and bypass hits.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int w = 0; w < 4; w++) begin
        c_en[w]   = 1'($urandom % 2);
        c_addr[w] = ($urandom % 4 == 0) ? 5'($urandom % 4) : 5'($urandom % 32);
        c_data[w] = $urandom;
      end
      for (int r = 0; r < 8; r++) begin
        r_en[r]   = ($urandom % 4) != 0;
        r_addr[r] = ($urandom % 2 == 1) ? c_addr[$urandom % 4] : 5'($urandom % 32);
      end
      if ($urandom % 512 == 0) begin
        rst_n = 1'b0;
        clear_model();
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
